// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x3 keypad matrix emulator and its scanner.
// Contents: key code constants, one-hot column strobes, FSM state encoding,
// key code -> (row, col) mapping, and row drive helper.
package keypad_pkg;

  localparam logic [3:0] KEY_1    = 4'd1;
  localparam logic [3:0] KEY_2    = 4'd2;
  localparam logic [3:0] KEY_3    = 4'd3;
  localparam logic [3:0] KEY_4    = 4'd4;
  localparam logic [3:0] KEY_5    = 4'd5;
  localparam logic [3:0] KEY_6    = 4'd6;
  localparam logic [3:0] KEY_7    = 4'd7;
  localparam logic [3:0] KEY_8    = 4'd8;
  localparam logic [3:0] KEY_9    = 4'd9;
  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_0    = 4'd11;
  localparam logic [3:0] KEY_HASH = 4'd12;

  localparam logic [2:0] COL1 = 3'b001;
  localparam logic [2:0] COL2 = 3'b010;
  localparam logic [2:0] COL3 = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BOUNCE_IN,
    ST_HOLD,
    ST_BOUNCE_OUT,
    ST_GAP
  } state_t;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } key_pos_t;

  function automatic logic key_valid(input logic [3:0] code);
    return (code >= KEY_1) && (code <= KEY_HASH);
  endfunction

  // Digits 1-9 fill rows 0-2 left to right; '*','0','#' sit on row 3.
  function automatic key_pos_t key_map(input logic [3:0] code);
    key_pos_t p;
    p = '0;
    if (code >= KEY_1 && code <= KEY_9) begin
      p.row = 2'((code - KEY_1) / 4'd3);
      p.col = 2'((code - KEY_1) % 4'd3);
    end else if (code >= KEY_STAR && code <= KEY_HASH) begin
      p.row = 2'd3;
      p.col = 2'(code - KEY_STAR);
    end
    return p;
  endfunction

  // The held key connects its column strobe to its row sense line; any
  // strobe pattern works, only the key's own column bit matters.
  function automatic logic [3:0] row_drive(input key_pos_t pos, input logic [2:0] col);
    logic       hit;
    logic [3:0] r;
    case (pos.col)
      2'd0:    hit = col[0];
      2'd1:    hit = col[1];
      2'd2:    hit = col[2];
      default: hit = 1'b0;
    endcase
    r = '0;
    r[pos.row] = hit;
    return r;
  endfunction

endpackage

// File: rtl/keypad_matrix_emulator_tick_gen.sv
// Free-running timing prescaler: tick is high for one clk every DIV clks.
// Ports: clk, rst (async, active-high), tick (high while count = DIV-1).
module tick_gen #(
  parameter int DIV = 12500
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/keypad_matrix_emulator.sv
// 4x3 keypad matrix emulator: passive end of a column-scan / row-sense keypad.
// Accepts scripted key presses over valid/ready, holds the key for HOLD_TICKS
// ticks, then stays released for GAP_TICKS ticks before taking the next one.
// Optional contact bounce at press/release edges when KEYPAD_BOUNCE_EN is
// defined (BOUNCE_TICKS ticks each, pressed level toggling every tick).
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   key_col[2:0]      column strobes from scanner
//   key_row[3:0]      registered row sense (1 clk behind key_col)
//   req_valid/req_key press request, req_ready high only in IDLE
//   busy              not IDLE
//   done              1-clk pulse on GAP -> IDLE
//   err               1-clk pulse after an invalid code is consumed
module keypad_matrix_emulator
  import keypad_pkg::*;
#(
  parameter int TICK_DIV     = 12500,
  parameter int HOLD_TICKS   = 200,
  parameter int GAP_TICKS    = 50,
  parameter int BOUNCE_TICKS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] key_col,
  output logic [3:0] key_row,
  input  logic       req_valid,
  input  logic [3:0] req_key,
  output logic       req_ready,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // Zero-length phases behave as one tick.
  localparam int HOLD_LIM = (HOLD_TICKS   < 1) ? 1 : HOLD_TICKS;
  localparam int GAP_LIM  = (GAP_TICKS    < 1) ? 1 : GAP_TICKS;
  localparam int BNC_LIM  = (BOUNCE_TICKS < 1) ? 1 : BOUNCE_TICKS;
  localparam int MAX_HG   = (HOLD_LIM > GAP_LIM) ? HOLD_LIM : GAP_LIM;
  localparam int MAX_LIM  = (MAX_HG > BNC_LIM) ? MAX_HG : BNC_LIM;
  localparam int CW       = $clog2(MAX_LIM + 1);

  state_t        state;
  logic [CW-1:0] phase;
  logic [3:0]    key;
  logic          tick;
  logic [CW-1:0] lim;
  logic          last;
  logic          pressed;
`ifdef KEYPAD_BOUNCE_EN
  logic          bnc;
`endif

  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  always_comb begin
    case (state)
      ST_HOLD: lim = CW'(HOLD_LIM - 1);
      ST_GAP:  lim = CW'(GAP_LIM - 1);
      default: lim = CW'(BNC_LIM - 1);
    endcase
  end

  // Phase ends on the tick that completes its tick count; the first tick
  // after entry may be partial.
  assign last = tick && (phase == lim);

`ifdef KEYPAD_BOUNCE_EN
  assign pressed = (state == ST_HOLD) ||
                   (((state == ST_BOUNCE_IN) || (state == ST_BOUNCE_OUT)) && bnc);
`else
  assign pressed = (state == ST_HOLD);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      phase   <= '0;
      key     <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      key_row <= '0;
`ifdef KEYPAD_BOUNCE_EN
      bnc     <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      err     <= 1'b0;
      key_row <= pressed ? row_drive(key_map(key), key_col) : 4'b0000;

      if (state != ST_IDLE && tick) phase <= phase + 1'b1;

      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            key <= req_key;
            if (key_valid(req_key)) begin
              phase <= '0;
`ifdef KEYPAD_BOUNCE_EN
              state <= ST_BOUNCE_IN;
              bnc   <= 1'b1;
`else
              state <= ST_HOLD;
`endif
            end else begin
              err <= 1'b1;
            end
          end
        end
`ifdef KEYPAD_BOUNCE_EN
        ST_BOUNCE_IN: begin
          if (tick) bnc <= ~bnc;
          if (last) begin
            state <= ST_HOLD;
            phase <= '0;
          end
        end
        ST_BOUNCE_OUT: begin
          if (tick) bnc <= ~bnc;
          if (last) begin
            state <= ST_GAP;
            phase <= '0;
          end
        end
`endif
        ST_HOLD: begin
          if (last) begin
            phase <= '0;
`ifdef KEYPAD_BOUNCE_EN
            state <= ST_BOUNCE_OUT;
            bnc   <= 1'b0;
`else
            state <= ST_GAP;
`endif
          end
        end
        ST_GAP: begin
          if (last) begin
            state <= ST_IDLE;
            phase <= '0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          phase <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Bench for keypad_matrix_emulator (TICK_DIV=4, HOLD_TICKS=5, GAP_TICKS=2,
// BOUNCE_TICKS=3). A schedule model predicts every output on every cycle
// from tick arithmetic; directed tests add literal expectations on top.
module tb_keypad_matrix_emulator;

  localparam int DIV = 4;
  localparam int HT  = 5;
  localparam int GT  = 2;
  localparam int BT  = 3;
`ifdef KEYPAD_BOUNCE_EN
  localparam bit BNC      = 1'b1;
  localparam int LIT_DLY  = 14;
  localparam int RISES    = 3;
  localparam int DONE_MIN = 49;
  localparam int DONE_MAX = 52;
`else
  localparam bit BNC      = 1'b0;
  localparam int LIT_DLY  = 3;
  localparam int RISES    = 1;
  localparam int DONE_MIN = 25;
  localparam int DONE_MAX = 28;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] key_col = 3'b000;
  logic [3:0] key_row;
  logic       req_valid = 1'b0;
  logic [3:0] req_key = 4'd0;
  logic       req_ready, busy, done, err;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  keypad_matrix_emulator #(
    .TICK_DIV(DIV), .HOLD_TICKS(HT), .GAP_TICKS(GT), .BOUNCE_TICKS(BT)
  ) dut (
    .clk(clk), .rst(rst), .key_col(key_col), .key_row(key_row),
    .req_valid(req_valid), .req_key(req_key), .req_ready(req_ready),
    .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- schedule model ----------------
  // Edges are numbered from 1 after reset release; tick edges are multiples
  // of DIV. Phase boundaries are the n-th tick edge after the phase start.
  int         cyc    = 0;
  bit         active = 1'b0;
  int         a_e = 0, bin_e = 0, eh_e = 0, bout_e = 0, eg_e = 0, err_e = -1;
  logic [3:0] mkey = 4'd0;

  function automatic int nt(input int e, input int n);
    int m;
    m = (n < 1) ? 1 : n;
    return (e / DIV + m) * DIV;
  endfunction

  function automatic int nticks(input int x, input int y);
    return y / DIV - x / DIV;
  endfunction

  function automatic bit busy_at(input int p);
    return active && (p >= a_e) && (p < eg_e);
  endfunction

  function automatic bit pressed_at(input int p);
    if (!active || p < a_e) return 1'b0;
    if (p < bin_e)  return (nticks(a_e, p) % 2) == 0;
    if (p < eh_e)   return 1'b1;
    if (p < bout_e) return (nticks(eh_e, p) % 2) == 1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] row_of(input logic [3:0] code, input logic [2:0] col);
    int r, c;
    logic [3:0] v;
    if (code <= 4'd9) begin
      r = (int'(code) - 1) / 3;
      c = (int'(code) - 1) % 3;
    end else begin
      r = 3;
      c = int'(code) - 10;
    end
    v = 4'b0000;
    v[r] = col[c];
    return v;
  endfunction

  initial begin : compare
    logic       v, r;
    logic [3:0] k;
    logic [2:0] c;
    logic [3:0] exp_row;
    forever begin
      @(posedge clk);
      v = req_valid; k = req_key; c = key_col; r = rst;
      if (r) begin
        cyc = 0; active = 1'b0; err_e = -1;
      end else begin
        cyc++;
        if (v && !busy_at(cyc - 1)) begin
          if (k >= 4'd1 && k <= 4'd12) begin
            active = 1'b1; mkey = k; a_e = cyc;
            bin_e  = BNC ? nt(a_e, BT) : a_e;
            eh_e   = nt(bin_e, HT);
            bout_e = BNC ? nt(eh_e, BT) : eh_e;
            eg_e   = nt(bout_e, GT);
          end else begin
            err_e = cyc;
          end
        end
      end
      #1;
      exp_row = pressed_at(cyc - 1) ? row_of(mkey, c) : 4'b0000;
      chk("key_row",   key_row,   exp_row);
      chk("req_ready", req_ready, !busy_at(cyc));
      chk("busy",      busy,      busy_at(cyc));
      chk("done",      done,      active && (cyc == eg_e));
      chk("err",       err,       cyc == err_e);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_idle();
    int i;
    i = 0;
    while (!(req_ready && !busy) && i < 400) begin
      @(negedge clk);
      i++;
    end
    chk("idle_timeout", busy, 1'b0);
  endtask

  // Returns at the negedge right after the accepting edge.
  task automatic offer(input logic [3:0] k);
    @(negedge clk);
    req_valid = 1'b1;
    req_key   = k;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin : stim
    int         i, hold_cnt, done_at, rdy_hi, e, b, rises;
    logic       prev;
    logic [3:0] r1, r2;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_key_row", key_row, 4'b0000);
    chk("rst_ready",   req_ready, 1'b1);
    chk("rst_busy",    busy, 1'b0);
    chk("rst_done",    done, 1'b0);
    chk("rst_err",     err, 1'b0);
    rst = 1'b0;

    // key 5 on column 2
    key_col = 3'b010;
    wait_idle();
    offer(4'd5);
    hold_cnt = 0; done_at = -1; rdy_hi = 0; i = 0;
    while (done_at < 0 && i < 200) begin
      if (key_row == 4'b0010) hold_cnt++;
      if (done) done_at = i;
      else if (req_ready) rdy_hi++;
      @(negedge clk);
      i++;
    end
`ifndef KEYPAD_BOUNCE_EN
    chk("k5_hold_len_ok", (hold_cnt >= 17 && hold_cnt <= 20), 1'b1);
`endif
    chk("k5_done_lat_ok", (done_at >= DONE_MIN && done_at <= DONE_MAX), 1'b1);
    chk("k5_ready_low",   rdy_hi, 0);

    // key 11 ('0') across all three strobes, then key 10 ('*')
    wait_idle();
    offer(4'd11);
    repeat (LIT_DLY - 1) @(negedge clk);
    key_col = 3'b001; @(negedge clk); chk("k0_col1", key_row, 4'b0000);
    key_col = 3'b010; @(negedge clk); chk("k0_col2", key_row, 4'b1000);
    key_col = 3'b100; @(negedge clk); chk("k0_col3", key_row, 4'b0000);
    wait_idle();
    key_col = 3'b001;
    offer(4'd10);
    repeat (LIT_DLY) @(negedge clk);
    chk("kstar_col1", key_row, 4'b1000);

    // invalid code, then a normal key 3
    wait_idle();
    key_col = 3'b100;
    offer(4'd14);
    e = 0; b = 0;
    for (int j = 0; j < 6; j++) begin
      if (err) e++;
      if (busy) b++;
      @(negedge clk);
    end
    chk("bad_err_pulses", e, 1);
    chk("bad_busy_cycles", b, 0);
    offer(4'd3);
    repeat (LIT_DLY) @(negedge clk);
    chk("k3_col3", key_row, 4'b0001);

    // async reset during key 9 hold
    wait_idle();
    key_col = 3'b100;
    offer(4'd9);
    repeat (LIT_DLY) @(negedge clk);
    chk("k9_pressed", key_row, 4'b0100);
    #2 rst = 1'b1;
    #1;
    chk("arst_key_row", key_row, 4'b0000);
    chk("arst_ready",   req_ready, 1'b1);
    chk("arst_busy",    busy, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // valid held high: key 1 then key 2
    wait_idle();
    key_col = 3'b001;
    @(negedge clk);
    req_valid = 1'b1; req_key = 4'd1;
    i = 0;
    while (!busy && i < 50) begin @(negedge clk); i++; end
    req_key = 4'd2;
    r1 = 4'b0000; i = 0;
    while (!done && i < 400) begin r1 |= key_row; @(negedge clk); i++; end
    chk("held_done1", done, 1'b1);
    key_col = 3'b010;
    @(negedge clk);
    chk("held_second_accept", busy, 1'b1);
    req_valid = 1'b0;
    r2 = 4'b0000; i = 0;
    while (!done && i < 400) begin r2 |= key_row; @(negedge clk); i++; end
    chk("held_done2", done, 1'b1);
    chk("held_k1_row", r1, 4'b0001);
    chk("held_k2_row", r2, 4'b0001);

    // press edge shape: rising edges of row0 over one key 1 press
    wait_idle();
    key_col = 3'b001;
    offer(4'd1);
    prev = key_row[0]; rises = 0; i = 0;
    while (!done && i < 400) begin
      if (key_row[0] && !prev) rises++;
      prev = key_row[0];
      @(negedge clk);
      i++;
    end
    chk("k1_row_rises", rises, RISES);

    wait_idle();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: run did not complete, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
